// File: rtl/led_pkg.sv
// led_pkg: shared types and digit limits for the LED display path.
// Used by bcd_time_counter and its bcd_digit sub-module.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_ONES_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

    function automatic bcd_t fix_digit(input bcd_t d, input bcd_t lim);
        return (d > lim) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit that rolls over at LIMIT, with load and clear.
// carry/borrow are combinational so a chain advances in a single cycle.
module bcd_digit
    import led_pkg::*;
#(
    parameter bcd_t LIMIT = SEC_ONES_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic load,
    input  bcd_t load_val,
    input  logic clr,
    output bcd_t value,
    output logic carry,
    output logic borrow
);

    assign carry  = inc && (value == LIMIT);
    assign borrow = dec && (value == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 4'd0;
        end else if (clr) begin
            value <= 4'd0;
        end else if (load) begin
            value <= fix_digit(load_val, LIMIT);
        end else if (inc) begin
            value <= carry ? 4'd0 : value + 4'd1;
        end else if (dec) begin
            value <= borrow ? LIMIT : value - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: MM:SS BCD counter with start/stop/clear/load control.
// Define TIME_CNT_DOWN_EN to add the dir input, done pulse and down counting.
module bcd_time_counter
    import led_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_value,
`ifdef TIME_CNT_DOWN_EN
    input  logic        dir,
    output logic        done,
`endif
    output logic [15:0] digits,
    output logic        running,
    output logic        wrap
);

    localparam bcd_t MAX_T = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MAX_O = bcd_t'(MAX_MIN % 10);
    // Below 10 minutes the ones digit itself is the minutes limit.
    localparam bcd_t MO_LIM = (MAX_MIN >= 10) ? SEC_ONES_MAX : MAX_O;

    state_t state, next_state;

    bcd_t so, st, mo, mt;
    bcd_t ld_so, ld_st, ld_mo, ld_mt;
    logic so_c, so_b, st_c, st_b, mo_c, mo_b, mt_c, mt_b;
    logic count, count_up, count_dn;
    logic at_max, at_zero, at_one;
    logic wrap_now, done_now, clr_all;
    logic unused_flags;

    assign at_max  = ({mt, mo} == {MAX_T, MAX_O})
                  && (st == SEC_TENS_MAX)
                  && (so == SEC_ONES_MAX);
    assign at_zero = ({mt, mo, st, so} == 16'h0000);
    assign at_one  = ({mt, mo, st, so} == 16'h0001);

    // Only a tick in RUN with no higher-priority control is counted.
    assign count = (state == RUN) && tick && !clear && !load && !stop;

`ifdef TIME_CNT_DOWN_EN
    assign count_up = count && !dir;
    assign count_dn = count && dir;
    assign done_now = count_dn && (at_zero || at_one);
`else
    assign count_up = count;
    assign count_dn = 1'b0;
    assign done_now = 1'b0;
`endif

    assign wrap_now = count_up && at_max;
    assign clr_all  = clear || wrap_now;

    always_comb begin
        ld_so = fix_digit(load_value[3:0], SEC_ONES_MAX);
        ld_st = fix_digit(load_value[7:4], SEC_TENS_MAX);
        ld_mo = fix_digit(load_value[11:8], SEC_ONES_MAX);
        ld_mt = fix_digit(load_value[15:12], SEC_ONES_MAX);
        if ({ld_mt, ld_mo} > {MAX_T, MAX_O}) begin
            ld_mt = 4'd0;
            ld_mo = 4'd0;
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else if (load) begin
            next_state = state;
        end else if (stop) begin
            if (state == RUN) next_state = PAUSE;
        end else if (start) begin
            if (state != RUN) next_state = RUN;
        end else if (done_now) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= next_state;
            running <= (next_state == RUN);
            wrap    <= wrap_now;
        end
    end

`ifdef TIME_CNT_DOWN_EN
    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else     done <= done_now;
    end
`endif

    bcd_digit #(.LIMIT(SEC_ONES_MAX)) u_so (
        .clk(clk), .rst(rst),
        .inc(count_up && !at_max), .dec(count_dn && !at_zero),
        .load(load), .load_val(ld_so), .clr(clr_all),
        .value(so), .carry(so_c), .borrow(so_b)
    );

    bcd_digit #(.LIMIT(SEC_TENS_MAX)) u_st (
        .clk(clk), .rst(rst),
        .inc(so_c), .dec(so_b),
        .load(load), .load_val(ld_st), .clr(clr_all),
        .value(st), .carry(st_c), .borrow(st_b)
    );

    bcd_digit #(.LIMIT(MO_LIM)) u_mo (
        .clk(clk), .rst(rst),
        .inc(st_c), .dec(st_b),
        .load(load), .load_val(ld_mo), .clr(clr_all),
        .value(mo), .carry(mo_c), .borrow(mo_b)
    );

    bcd_digit #(.LIMIT(MAX_T)) u_mt (
        .clk(clk), .rst(rst),
        .inc(mo_c), .dec(mo_b),
        .load(load), .load_val(ld_mt), .clr(clr_all),
        .value(mt), .carry(mt_c), .borrow(mt_b)
    );

    // The top digit never rolls: MAX_MIN:59 clears the whole chain first.
    assign unused_flags = mt_c ^ mt_b;

    assign digits = {mt, mo, st, so};

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed vectors for the MM:SS BCD counter.
// Down-count vectors run only when TIME_CNT_DOWN_EN is defined.
module tb_bcd_time_counter;

    logic        clk = 1'b0;
    logic        rst, tick, start, stop, clear, load;
    logic [15:0] load_value;
    logic [15:0] digits;
    logic        running, wrap;
`ifdef TIME_CNT_DOWN_EN
    logic        dir, done;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_time_counter #(.MAX_MIN(59)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .start(start), .stop(stop), .clear(clear),
        .load(load), .load_value(load_value),
`ifdef TIME_CNT_DOWN_EN
        .dir(dir), .done(done),
`endif
        .digits(digits), .running(running), .wrap(wrap)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        tick = 0; start = 0; stop = 0; clear = 0; load = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1; load_value = v;
        cyc(1);
        load = 0;
    endtask

    initial begin
        rst = 1; load_value = 16'h0;
        idle_in();
`ifdef TIME_CNT_DOWN_EN
        dir = 0;
`endif
        cyc(2);
        chk("rst_digits", digits, 16'h0000);
        chk("rst_running", {15'd0, running}, 16'd1 - 16'd1);
        chk("rst_wrap", {15'd0, wrap}, 16'h0000);
`ifdef TIME_CNT_DOWN_EN
        chk("rst_done", {15'd0, done}, 16'h0000);
`endif
        rst = 0;

        // tick in IDLE ignored
        tick = 1; cyc(2); tick = 0;
        chk("idle_tick", digits, 16'h0000);

        start = 1; cyc(1); start = 0;
        chk("start_run", {15'd0, running}, 16'h0001);
        chk("start_hold", digits, 16'h0000);
        tick = 1; cyc(10); tick = 0;
        chk("ten_ticks", digits, 16'h0010);
        chk("ten_run", {15'd0, running}, 16'h0001);

        do_load(16'h0958);
        chk("load_0958", digits, 16'h0958);
        chk("load_keeps_run", {15'd0, running}, 16'h0001);
        start = 1; cyc(1); start = 0;
        tick = 1; cyc(1);
        chk("tick_0959", digits, 16'h0959);
        cyc(1); tick = 0;
        chk("tick_1000", digits, 16'h1000);

        do_load(16'h0059);
        tick = 1; cyc(1); tick = 0;
        chk("tick_0100", digits, 16'h0100);

        do_load(16'h5959);
        chk("pre_wrap_wrap", {15'd0, wrap}, 16'h0000);
        tick = 1; cyc(1); tick = 0;
        chk("wrap_digits", digits, 16'h0000);
        chk("wrap_pulse", {15'd0, wrap}, 16'h0001);
        cyc(1);
        chk("wrap_once", {15'd0, wrap}, 16'h0000);

        load = 1; load_value = 16'h1234; tick = 1;
        cyc(1);
        load = 0; tick = 0;
        chk("load_tick", digits, 16'h1234);

        stop = 1; tick = 1; cyc(1); stop = 0;
        chk("stop_tick", digits, 16'h1234);
        chk("stop_run", {15'd0, running}, 16'h0000);
        cyc(3); tick = 0;
        chk("pause_ign", digits, 16'h1234);
        start = 1; tick = 1; cyc(1); start = 0;
        chk("start_tick", digits, 16'h1234);
        chk("resume_run", {15'd0, running}, 16'h0001);
        cyc(1); tick = 0;
        chk("resume_cnt", digits, 16'h1235);

        start = 1; stop = 1; cyc(1); start = 0; stop = 0;
        chk("ss_run", {15'd0, running}, 16'h0000);
        start = 1; cyc(1); start = 0;

        do_load(16'h7A5C);
        chk("load_7A5C", digits, 16'h0050);
        do_load(16'h0F6A);
        chk("load_0F6A", digits, 16'h0000);
        do_load(16'h5907);
        tick = 1; cyc(1);
        chk("run_5908", digits, 16'h5908);
        clear = 1; cyc(1); clear = 0;
        chk("clear_dig", digits, 16'h0000);
        chk("clear_run", {15'd0, running}, 16'h0000);
        cyc(2); tick = 0;
        chk("clear_idle", digits, 16'h0000);
        start = 1; stop = 1; cyc(1); start = 0; stop = 0;
        chk("ss_idle", {15'd0, running}, 16'h0000);

        start = 1; cyc(1); start = 0;
        tick = 1; cyc(3);
        rst = 1; start = 1; load = 1; load_value = 16'h4444;
        cyc(1);
        rst = 0; start = 0; load = 0; tick = 0;
        chk("mid_rst_dig", digits, 16'h0000);
        chk("mid_rst_run", {15'd0, running}, 16'h0000);

`ifdef TIME_CNT_DOWN_EN
        dir = 1;
        do_load(16'h0001);
        start = 1; cyc(1); start = 0;
        tick = 1; cyc(1); tick = 0;
        chk("dn_zero", digits, 16'h0000);
        chk("dn_done", {15'd0, done}, 16'h0001);
        chk("dn_idle", {15'd0, running}, 16'h0000);
        chk("dn_nowrap", {15'd0, wrap}, 16'h0000);
        cyc(1);
        chk("dn_done1", {15'd0, done}, 16'h0000);
        do_load(16'h0100);
        start = 1; cyc(1); start = 0;
        tick = 1; cyc(1); tick = 0;
        chk("dn_0059", digits, 16'h0059);
        do_load(16'h0000);
        tick = 1; cyc(1); tick = 0;
        chk("dn_at0", digits, 16'h0000);
        chk("dn_at0_done", {15'd0, done}, 16'h0001);
        chk("dn_at0_idle", {15'd0, running}, 16'h0000);
        dir = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
